// File: rtl/icache_line_prefetcher.sv
// rtl/icache_line_prefetcher.sv - next-line instruction prefetcher between ICache and arbiter
// One-entry line buffer filled with line+1 after every demand or buffer hit.
module icache_line_prefetcher #(
   parameter int ADDR_WIDTH  = 32,
   parameter int LINE_WIDTH  = 256,
   parameter int OFFSET_BITS = 5
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  pf_enable,
   input  logic [ADDR_WIDTH-1:0] ic_address,
   input  logic                  ic_read,
   output logic                  ic_resp,
   output logic [LINE_WIDTH-1:0] ic_rdata,
   output logic [ADDR_WIDTH-1:0] arb_address,
   output logic                  arb_read,
   input  logic                  arb_resp,
   input  logic [LINE_WIDTH-1:0] arb_rdata
);

   localparam int TAG_WIDTH = ADDR_WIDTH - OFFSET_BITS;

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_DEMAND   = 2'd1;
   localparam logic [1:0] S_RESPOND  = 2'd2;
   localparam logic [1:0] S_PREFETCH = 2'd3;

   logic [1:0]            state_q, state_d;
   logic                  ic_resp_q, ic_resp_d;
   logic [LINE_WIDTH-1:0] ic_rdata_q, ic_rdata_d;
   logic                  arb_read_q, arb_read_d;
   logic [TAG_WIDTH-1:0]  arb_tag_q, arb_tag_d;
   logic                  pf_valid_q, pf_valid_d;
   logic [TAG_WIDTH-1:0]  pf_tag_q, pf_tag_d;
   logic [LINE_WIDTH-1:0] pf_data_q, pf_data_d;
   logic [TAG_WIDTH-1:0]  nxt_tag_q, nxt_tag_d;
   logic                  nxt_wrap_q, nxt_wrap_d;

   logic [TAG_WIDTH-1:0]  ic_tag;
   logic                  pf_hit;
   logic                  unused_offset;

   assign ic_tag        = ic_address[ADDR_WIDTH-1:OFFSET_BITS];
   assign unused_offset = ^ic_address[OFFSET_BITS-1:0];
   assign pf_hit        = pf_valid_q && (ic_tag == pf_tag_q);

   always_comb begin
      state_d    = state_q;
      ic_resp_d  = 1'b0;
      ic_rdata_d = ic_rdata_q;
      arb_read_d = arb_read_q;
      arb_tag_d  = arb_tag_q;
      pf_valid_d = pf_valid_q;
      pf_tag_d   = pf_tag_q;
      pf_data_d  = pf_data_q;
      nxt_tag_d  = nxt_tag_q;
      nxt_wrap_d = nxt_wrap_q;

      case (state_q)
         S_IDLE: begin
            // A request still held in the cycle its response is visible is not a new request.
            if (ic_read && !ic_resp_q) begin
               if (pf_hit) begin
                  ic_resp_d  = 1'b1;
                  ic_rdata_d = pf_data_q;
                  nxt_tag_d  = pf_tag_q + 1'b1;
                  nxt_wrap_d = &pf_tag_q;
                  pf_valid_d = 1'b0;
                  state_d    = (pf_enable && !(&pf_tag_q)) ? S_PREFETCH : S_IDLE;
               end else begin
                  arb_read_d = 1'b1;
                  arb_tag_d  = ic_tag;
                  state_d    = S_DEMAND;
               end
            end
         end
         S_DEMAND: begin
            if (arb_resp) begin
               arb_read_d = 1'b0;
               ic_rdata_d = arb_rdata;
               ic_resp_d  = 1'b1;
               nxt_tag_d  = arb_tag_q + 1'b1;
               nxt_wrap_d = &arb_tag_q;
               state_d    = S_RESPOND;
            end
         end
         S_RESPOND: begin
            if (pf_enable && !nxt_wrap_q) begin
               arb_read_d = 1'b1;
               arb_tag_d  = nxt_tag_q;
               state_d    = S_PREFETCH;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_PREFETCH: begin
            // Entered from a hit with no request yet outstanding; issue it one cycle later.
            if (!arb_read_q) begin
               arb_read_d = 1'b1;
               arb_tag_d  = nxt_tag_q;
            end else if (arb_resp) begin
               arb_read_d = 1'b0;
               pf_data_d  = arb_rdata;
               pf_tag_d   = nxt_tag_q;
               pf_valid_d = 1'b1;
               state_d    = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (!pf_enable) begin
         pf_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         ic_resp_q  <= 1'b0;
         ic_rdata_q <= '0;
         arb_read_q <= 1'b0;
         arb_tag_q  <= '0;
         pf_valid_q <= 1'b0;
         pf_tag_q   <= '0;
         pf_data_q  <= '0;
         nxt_tag_q  <= '0;
         nxt_wrap_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ic_resp_q  <= ic_resp_d;
         ic_rdata_q <= ic_rdata_d;
         arb_read_q <= arb_read_d;
         arb_tag_q  <= arb_tag_d;
         pf_valid_q <= pf_valid_d;
         pf_tag_q   <= pf_tag_d;
         pf_data_q  <= pf_data_d;
         nxt_tag_q  <= nxt_tag_d;
         nxt_wrap_q <= nxt_wrap_d;
      end
   end

   assign ic_resp     = ic_resp_q;
   assign ic_rdata    = ic_rdata_q;
   assign arb_read    = arb_read_q;
   assign arb_address = {arb_tag_q, {OFFSET_BITS{1'b0}}};

endmodule
